// File: rtl/nes_pad_reader_pkg.sv
// Shared definitions for the NES joypad reader: FSM encodings, frame geometry
// and the button bit positions that consumers of the button word rely on.
package nes_pad_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int LATCH_TICKS = 2;
    localparam int NUM_BITS    = 8;
    localparam int BIT_CNT_W   = $clog2(NUM_BITS);
    localparam int LATCH_CNT_W = $clog2(LATCH_TICKS);

    // Position of each button inside the published word (1 = pressed)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_tick_gen.sv
// Half-period tick generator: one-cycle pulse every HALF_PERIOD_CYC cycles,
// restartable so the first phase after a clear is always full length.
module nes_tick_gen #(
    parameter int HALF_PERIOD_CYC = 300
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(HALF_PERIOD_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/nes_pad_reader.sv
// NES joypad sequencer: latches the pad, clocks out eight serial bits and
// publishes the decoded button word, either on request or on a periodic poll.
module nes_pad_reader
    import nes_pad_reader_pkg::*;
#(
    parameter int HALF_PERIOD_CYC = 300,
    parameter int POLL_CYC        = 833333,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       auto_en,
    input  logic       start,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       busy
);

    localparam int POLL_W = $clog2(POLL_CYC);
    localparam logic [POLL_W-1:0]      POLL_LAST  = POLL_W'(POLL_CYC - 1);
    localparam logic [BIT_CNT_W-1:0]   BIT_LAST   = BIT_CNT_W'(NUM_BITS - 1);
    localparam logic [LATCH_CNT_W-1:0] LATCH_LAST = LATCH_CNT_W'(LATCH_TICKS - 1);

    state_t                   state_q, state_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [LATCH_CNT_W-1:0]   latch_cnt_q, latch_cnt_d;
    logic [NUM_BITS-1:0]      shift_q, shift_d;
    logic                     pending_q, pending_d;
    logic [POLL_W-1:0]        poll_q;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     pad_latch_q, pad_clk_q, valid_q;
    logic [NUM_BITS-1:0]      buttons_q;
    logic                     tick, tick_clear, poll_wrap, request, pad_sync;

    // Pad line idles high (no button pressed), so the chain resets to ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_data};
        end
    end
    assign pad_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_q <= '0;
        end else if (poll_wrap) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_q + 1'b1;
        end
    end
    assign poll_wrap = (poll_q == POLL_LAST);
    assign request   = start | (auto_en & poll_wrap);

    nes_tick_gen #(
        .HALF_PERIOD_CYC(HALF_PERIOD_CYC)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clear(tick_clear),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        latch_cnt_d = latch_cnt_q;
        shift_d     = shift_q;
        pending_d   = pending_q;
        tick_clear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (request || pending_q) begin
                    state_d     = ST_LATCH;
                    tick_clear  = 1'b1;
                    bit_cnt_d   = '0;
                    latch_cnt_d = '0;
                    pending_d   = 1'b0;
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    if (latch_cnt_q == LATCH_LAST) begin
                        state_d     = ST_LOW;
                        latch_cnt_d = '0;
                    end else begin
                        latch_cnt_d = latch_cnt_q + 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (tick) begin
                    shift_d[bit_cnt_q] = ~pad_sync;
                    state_d            = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        state_d   = ST_LOW;
                    end
                end
            end
            ST_DONE: begin
                // A request landing in DONE itself is served like a pending one
                if (pending_q || request) begin
                    state_d     = ST_LATCH;
                    tick_clear  = 1'b1;
                    bit_cnt_d   = '0;
                    latch_cnt_d = '0;
                    pending_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (request && (state_q == ST_LATCH || state_q == ST_LOW || state_q == ST_HIGH)) begin
            pending_d = 1'b1;
        end
    end

    // Pin outputs are decoded from the next state so they change on the same
    // edge as the state register and never glitch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            latch_cnt_q <= '0;
            shift_q     <= '0;
            pending_q   <= 1'b0;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b0;
            valid_q     <= 1'b0;
            buttons_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            latch_cnt_q <= latch_cnt_d;
            shift_q     <= shift_d;
            pending_q   <= pending_d;
            pad_latch_q <= (state_d == ST_LATCH);
            pad_clk_q   <= (state_d == ST_HIGH);
            valid_q     <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                buttons_q <= shift_q;
            end
        end
    end

    assign pad_latch     = pad_latch_q;
    assign pad_clk       = pad_clk_q;
    assign buttons       = buttons_q;
    assign buttons_valid = valid_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader with a 4021-style pad model,
// a scoreboard of latched pad words and a continuous pin-protocol monitor.
module tb_nes_pad_reader;

    localparam int HP        = 4;
    localparam int POLL      = 200;
    localparam int FRAME_LAT = 18 * HP + 2;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       auto_en = 1'b0;
    logic       start   = 1'b0;
    logic       pad_data = 1'b1;
    logic       pad_latch, pad_clk, buttons_valid, busy;
    logic [7:0] buttons;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nes_pad_reader #(
        .HALF_PERIOD_CYC(HP),
        .POLL_CYC       (POLL),
        .SYNC_STAGES    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .auto_en      (auto_en),
        .start        (start),
        .pad_data     (pad_data),
        .pad_latch    (pad_latch),
        .pad_clk      (pad_clk),
        .buttons      (buttons),
        .buttons_valid(buttons_valid),
        .busy         (busy)
    );

    // Pad model: reloads while LATCH is high, shifts on each CLK rise,
    // drives the inverted current bit, and reads 1 once the word is exhausted.
    logic [7:0] bfm_word     = 8'h00;
    logic [7:0] bfm_sr       = 8'h00;
    logic       toggle_mode  = 1'b0;
    logic       tog_phase    = 1'b0;
    logic       b_prev_latch = 1'b0;
    logic       b_prev_clk   = 1'b0;
    logic [7:0] load_word;

    assign load_word = toggle_mode ? (tog_phase ? 8'h00 : 8'hFF) : bfm_word;

    always @(posedge clk) begin
        b_prev_latch <= pad_latch;
        b_prev_clk   <= pad_clk;
        if (pad_latch) begin
            bfm_sr   <= load_word;
            pad_data <= ~load_word[0];
        end else if (pad_clk && !b_prev_clk) begin
            bfm_sr   <= {1'b0, bfm_sr[7:1]};
            pad_data <= ~bfm_sr[1];
        end
        if (!toggle_mode) begin
            tog_phase <= 1'b0;
        end else if (!pad_latch && b_prev_latch) begin
            tog_phase <= ~tog_phase;
        end
    end

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_q [$];

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts one frame and returns the published word and the cycle count
    // from the edge that saw start to the sample where buttons_valid is high.
    task automatic run_frame(input logic [7:0] word, output logic [7:0] got, output int lat);
        bfm_word = word;
        pulse_start();
        lat = 1;
        while (!buttons_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        got = buttons;
        $display("frame word=%h buttons=%h latency=%0d", word, got, lat);
    endtask

    initial begin
        logic [7:0] got;
        int         lat;
        int         vt [$];
        int         nvalid;
        int         rises;
        int         n;
        logic       prev;

        vecs[0] = '{8'h81, 8'h81};
        vecs[1] = '{8'h01, 8'h01};
        vecs[2] = '{8'h80, 8'h80};
        vecs[3] = '{8'hFF, 8'hFF};
        vecs[4] = '{8'h00, 8'h00};
        vecs[5] = '{8'hA5, 8'hA5};

        fork
            begin : monitor
                logic m_pclk, m_latch;
                int   high_run, low_run, latch_run, rise_cnt;
                m_pclk = 1'b0; m_latch = 1'b0;
                high_run = 0; low_run = 0; latch_run = 0; rise_cnt = 0;
                forever begin
                    @(negedge clk);
                    if (reset) begin
                        exp_q.delete();
                        m_pclk = 1'b0; m_latch = 1'b0;
                        high_run = 0; low_run = 0; latch_run = 0; rise_cnt = 0;
                    end else begin
                        if (buttons_valid) begin
                            chk_int("pad_clk_rises", rise_cnt, 8);
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL scoreboard: got %h expected none pending", buttons);
                            end else begin
                                chk8("scoreboard", buttons, exp_q.pop_front());
                            end
                        end
                        if (pad_latch && !m_latch) begin
                            exp_q.push_back(load_word);
                            rise_cnt = 0;
                            low_run  = 0;
                        end
                        if (pad_latch) latch_run++;
                        if (!pad_latch && m_latch) begin
                            chk_int("latch_len", latch_run, 2 * HP);
                            latch_run = 0;
                        end
                        if (pad_clk != m_pclk) chk_int("clk_edge_in_latch", int'(pad_latch), 0);
                        if (pad_clk && !m_pclk) begin
                            rise_cnt++;
                            chk_int("low_phase", low_run, HP);
                            low_run = 0;
                        end
                        if (!pad_clk && m_pclk) begin
                            chk_int("high_phase", high_run, HP);
                            high_run = 0;
                        end
                        if (pad_clk) high_run++;
                        else if (busy && !pad_latch) low_run++;
                        m_pclk  = pad_clk;
                        m_latch = pad_latch;
                    end
                end
            end
        join_none

        // Reset state
        #1;
        chk_int("rst_latch_async", int'(pad_latch), 0);
        repeat (3) @(negedge clk);
        chk_int("rst_pad_clk", int'(pad_clk), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_valid", int'(buttons_valid), 0);
        chk8("rst_buttons", buttons, 8'h00);
        #2 reset = 1'b0;

        // Single manual frames from a table
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].word, got, lat);
            chk8("tbl_buttons", got, vecs[i].exp);
            chk_int("tbl_latency", lat, FRAME_LAT);
            repeat (3) @(negedge clk);
            chk_int("idle_busy", int'(busy), 0);
            chk_int("idle_valid", int'(buttons_valid), 0);
        end

        // Auto-poll: 1000 cycles of auto_en give exactly five frames, 200 apart;
        // dropping auto_en lets any frame in flight finish
        bfm_word = 8'h5A;
        auto_en  = 1'b1;
        for (int c = 1; c <= 1200; c++) begin
            @(negedge clk);
            if (c == 1000) auto_en = 1'b0;
            if (buttons_valid) begin
                vt.push_back(c);
                chk8("auto_value", buttons, 8'h5A);
                $display("auto frame at cycle %0d buttons=%h", c, buttons);
            end
        end
        chk_int("auto_frames", vt.size(), 5);
        for (int i = 1; i < vt.size(); i++) chk_int("auto_spacing", vt[i] - vt[i-1], POLL);
        chk_int("auto_idle_busy", int'(busy), 0);

        // Requests during a frame: one pending, further ones dropped
        bfm_word = 8'hC3;
        pulse_start();
        nvalid = 0;
        for (int c = 1; c <= 260; c++) begin
            if (buttons_valid) begin
                nvalid++;
                $display("pending test valid at cycle %0d buttons=%h", c, buttons);
                if (nvalid == 1) chk_int("pending_restart", int'(pad_latch), 1);
            end
            @(negedge clk);
            start = (c == 10 || c == 20);
        end
        start = 1'b0;
        chk_int("pending_frames", nvalid, 2);
        chk_int("pending_idle", int'(busy), 0);
        chk8("pending_buttons", buttons, 8'hC3);

        // Reset during HIGH(3), then a clean frame afterwards
        bfm_word = 8'h77;
        pulse_start();
        rises = 0;
        n     = 0;
        prev  = pad_clk;
        while (rises < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (pad_clk && !prev) rises++;
            prev = pad_clk;
        end
        chk_int("reach_high3", rises, 4);
        chk_int("pre_reset_clk", int'(pad_clk), 1);
        #2 reset = 1'b1;
        #1;
        chk_int("abort_pad_clk", int'(pad_clk), 0);
        chk_int("abort_latch", int'(pad_latch), 0);
        chk_int("abort_busy", int'(busy), 0);
        chk8("abort_buttons", buttons, 8'h00);
        $display("reset applied mid-frame");
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        run_frame(8'h3C, got, lat);
        chk8("post_reset_buttons", got, 8'h3C);
        chk_int("post_reset_latency", lat, FRAME_LAT);

        // Pad word alternates every frame
        toggle_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_frame(8'h00, got, lat);
            chk8("toggle_buttons", got, (k % 2 == 0) ? 8'hFF : 8'h00);
        end
        toggle_mode = 1'b0;
        repeat (5) @(negedge clk);
        chk_int("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
